// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths and CDB source codes for the writeback arbiter
package cdb_arbiter_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_LR_WIDTH = 4;
    localparam int MaxROB = 1 << ROB_LR_WIDTH;
    typedef enum logic {CDB_SRC_ALU = 1'b0, CDB_SRC_SLB = 1'b1} cdb_src_e;
endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: small power-of-two FIFO with flush, count and async reset
module cdb_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    // storage write at the tail; contents need no reset since count gates use
    always_ff @(posedge clk)
        if (en && !flush && push) mem[wp] <= din;
    // pointers wrap naturally at DEPTH; flush empties without touching storage
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else if (en) begin
            if (flush) begin
                wp <= '0;
                rp <= '0;
                count <= '0;
            end else begin
                wp <= wp + AW'(push);
                rp <= rp + AW'(pop);
                count <= count + CW'(push) - CW'(pop);
            end
        end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the ROB writeback CDB between RS and SLB; CDB_BYPASS_EN lets an idle source skip its FIFO
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int TAG_W = ROB_LR_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              Clear_flag,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_value,
    input  logic [DATA_W-1:0] alu_jumppc,
    input  logic              alu_jumppc_vld,
    input  logic              slb_valid,
    output logic              slb_ready,
    input  logic [TAG_W-1:0]  slb_tag,
    input  logic [DATA_W-1:0] slb_value,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_value,
    output logic [DATA_W-1:0] cdb_jumppc,
    output logic              cdb_jumppc_vld,
    output logic              cdb_src
);
    localparam int EW = TAG_W + 2 * DATA_W + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [EW-1:0] a_in, s_in, a_head, s_head, a_sel, s_sel, g_ent;
    logic [CW-1:0] a_cnt, s_cnt;
    logic act, a_empty, s_empty, a_acc, s_acc, a_req, s_req;
    logic a_gnt, s_gnt, a_pop, s_pop, a_push, s_push;
    cdb_src_e rr_last;
    assign act = rdy & !Clear_flag;
    assign a_in = {alu_tag, alu_value, alu_jumppc, alu_jumppc_vld};
    assign s_in = {slb_tag, slb_value, {DATA_W{1'b0}}, 1'b0};
    assign alu_ready = act & (a_cnt < CW'(FIFO_DEPTH));
    assign slb_ready = act & (s_cnt < CW'(FIFO_DEPTH));
    assign a_empty = a_cnt == '0;
    assign s_empty = s_cnt == '0;
    assign a_acc = alu_valid & alu_ready;
    assign s_acc = slb_valid & slb_ready;
`ifdef CDB_BYPASS_EN
    assign a_req = !a_empty | a_acc;
    assign s_req = !s_empty | s_acc;
    assign a_sel = a_empty ? a_in : a_head;
    assign s_sel = s_empty ? s_in : s_head;
`else
    assign a_req = !a_empty;
    assign s_req = !s_empty;
    assign a_sel = a_head;
    assign s_sel = s_head;
`endif
    assign a_gnt = act & a_req & (!s_req | rr_last == CDB_SRC_SLB);
    assign s_gnt = act & s_req & !a_gnt;
    assign a_pop = a_gnt & !a_empty;
    assign s_pop = s_gnt & !s_empty;
    assign a_push = a_acc & !(a_gnt & a_empty);
    assign s_push = s_acc & !(s_gnt & s_empty);
    assign g_ent = s_gnt ? s_sel : a_sel;
    cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_alu_fifo (
        .clk(clk), .rst(rst), .en(rdy), .flush(Clear_flag), .push(a_push), .pop(a_pop),
        .din(a_in), .dout(a_head), .count(a_cnt)
    );
    cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_slb_fifo (
        .clk(clk), .rst(rst), .en(rdy), .flush(Clear_flag), .push(s_push), .pop(s_pop),
        .din(s_in), .dout(s_head), .count(s_cnt)
    );
    // registered CDB: flush suppresses grants so valid drops; fields hold when idle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag <= '0;
            cdb_value <= '0;
            cdb_jumppc <= '0;
            cdb_jumppc_vld <= 1'b0;
            cdb_src <= 1'b0;
            rr_last <= CDB_SRC_SLB;
        end else if (rdy) begin
            cdb_valid <= a_gnt | s_gnt;
            if (a_gnt | s_gnt) begin
                {cdb_tag, cdb_value, cdb_jumppc, cdb_jumppc_vld} <= g_ent;
                cdb_src <= s_gnt;
                rr_last <= cdb_src_e'(s_gnt);
            end
        end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed checks of cdb_arbiter against a queue-based reference model
module tb_cdb_arbiter;
    localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed {
        logic [3:0] tag;
        logic [31:0] val;
        logic [31:0] jpc;
        logic jv;
    } ent_t;
    logic clk = 1'b0, rst, rdy, Clear_flag;
    logic alu_valid, alu_ready, alu_jumppc_vld, slb_valid, slb_ready;
    logic [3:0] alu_tag, slb_tag, cdb_tag;
    logic [31:0] alu_value, alu_jumppc, slb_value, cdb_value, cdb_jumppc;
    logic cdb_valid, cdb_jumppc_vld, cdb_src;
    int n_vec = 0, n_err = 0;
    ent_t qa[$], qs[$];
    ent_t m_ent;
    bit m_valid, m_src, m_rr;
    always #5 clk = ~clk;
    cdb_arbiter #(.DATA_W(32), .TAG_W(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(Clear_flag),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_tag(alu_tag), .alu_value(alu_value),
        .alu_jumppc(alu_jumppc), .alu_jumppc_vld(alu_jumppc_vld),
        .slb_valid(slb_valid), .slb_ready(slb_ready), .slb_tag(slb_tag), .slb_value(slb_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_jumppc(cdb_jumppc),
        .cdb_jumppc_vld(cdb_jumppc_vld), .cdb_src(cdb_src)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic ent_t mk(input logic [3:0] t, input logic [31:0] v, input logic [31:0] j, input bit jv);
        mk = '{tag: t, val: v, jpc: j, jv: jv};
    endfunction
    function automatic ent_t rnd();
        rnd = mk(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    endfunction
    task automatic chk_out();
        chk("cdb_valid", cdb_valid, m_valid);
        chk("cdb_tag", cdb_tag, m_ent.tag);
        chk("cdb_value", cdb_value, m_ent.val);
        chk("cdb_jumppc", cdb_jumppc, m_ent.jpc);
        chk("cdb_jumppc_vld", cdb_jumppc_vld, m_ent.jv);
        chk("cdb_src", cdb_src, m_src);
    endtask
    task automatic do_reset();
        alu_valid = 0; slb_valid = 0; rdy = 1; Clear_flag = 0;
        rst = 1;
        #1;
        qa.delete(); qs.delete();
        m_valid = 0; m_ent = '0; m_src = 0; m_rr = 1;
        chk_out();
        @(negedge clk);
        rst = 0;
    endtask
    task automatic step(input bit av, input ent_t ae, input bit sv, input ent_t se_in, input bit r, input bit c,
                        output bit aa, output bit sa);
        bit era, ers, ea, es, ha, hs, ga, gs;
        ent_t se;
        se = se_in; se.jpc = '0; se.jv = 1'b0;
        alu_valid = av; alu_tag = ae.tag; alu_value = ae.val; alu_jumppc = ae.jpc; alu_jumppc_vld = ae.jv;
        slb_valid = sv; slb_tag = se.tag; slb_value = se.val; rdy = r; Clear_flag = c;
        #1;
        era = r && !c && qa.size() < DEPTH;
        ers = r && !c && qs.size() < DEPTH;
        chk("alu_ready", alu_ready, era);
        chk("slb_ready", slb_ready, ers);
        aa = av && era;
        sa = sv && ers;
        @(posedge clk);
        if (r && c) begin
            qa.delete(); qs.delete(); m_valid = 0;
        end else if (r) begin
            ea = qa.size() == 0;
            es = qs.size() == 0;
            ha = !ea || (BYP && aa);
            hs = !es || (BYP && sa);
            ga = ha && (!hs || m_rr);
            gs = hs && !ga;
            m_valid = ga || gs;
            if (ga) begin m_ent = ea ? ae : qa.pop_front(); m_src = 0; m_rr = 0; end
            if (gs) begin m_ent = es ? se : qs.pop_front(); m_src = 1; m_rr = 1; end
            if (aa && !(ga && ea)) qa.push_back(ae);
            if (sa && !(gs && es)) qs.push_back(se);
        end
        @(negedge clk);
        chk_out();
    endtask
    task automatic idle(input int n, input bit r);
        bit aa, sa;
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, r, 0, aa, sa);
    endtask
    initial begin
        bit aa, sa;
        int ta, ts;
        do_reset();
        step(1, mk(3, 32'h11, 32'h40, 1), 0, '0, 1, 0, aa, sa);
        chk("t1_early_valid", cdb_valid, BYP);
        step(0, '0, 0, '0, 1, 0, aa, sa);
        chk("t1_tag", cdb_tag, 4'd3);
        chk("t1_value", cdb_value, 32'h11);
        chk("t1_src", cdb_src, 1'b0);
        idle(2, 1);
        ta = 1; ts = 9;
        for (int i = 0; i < 8; i++) begin
            step(ta <= 3, mk(4'(ta), 32'(ta * 16), 32'(ta * 4), 1), ts <= 11, mk(4'(ts), 32'(ts * 256), 0, 0), 1, 0, aa, sa);
            if (aa) ta++;
            if (sa) ts++;
        end
        idle(3, 1);
        step(1, rnd(), 1, rnd(), 1, 0, aa, sa);
        step(1, rnd(), 1, rnd(), 1, 0, aa, sa);
        step(1, rnd(), 0, '0, 1, 1, aa, sa);
        chk("clr_valid", cdb_valid, 1'b0);
        step(1, mk(5, 32'h55, 32'h0, 0), 0, '0, 1, 0, aa, sa);
        idle(3, 1);
        step(1, rnd(), 1, rnd(), 1, 0, aa, sa);
        step(1, rnd(), 1, rnd(), 1, 0, aa, sa);
        step(1, rnd(), 1, rnd(), 0, 0, aa, sa);
        idle(2, 0);
        idle(5, 1);
        step(0, '0, 1, mk(7, 32'h77, 0, 0), 1, 0, aa, sa);
        chk("byp_valid", cdb_valid, BYP);
        idle(2, 1);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 99) < 70, rnd(), $urandom_range(0, 99) < 60, rnd(),
                 $urandom_range(0, 99) < 88, $urandom_range(0, 99) < 4, aa, sa);
        end
        idle(4, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
